matmul_scheduler: RTL and testbench

Two-requester arbiter and sequencer for the shared `Matrix_Multiplication` engine. It accepts job descriptors from two masters (CPU register port and DMA) and grants the engine to one of them round-robin. It validates the job, clears the engine's accumulating result array, runs the engine, and watches for completion or timeout. It then holds the result for the owner until the owner acknowledges. The top level uses `grant` to steer the matrixA/matrixB inputs and the matrixC read path.

---
 rtl/matmul_scheduler_if.sv | 41 ++++
 rtl/matmul_scheduler.sv | 173 +++++++++++++++++
 tb/tb_matmul_scheduler.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_scheduler_if.sv
// matmul_scheduler_if: requester-facing bundle of the matmul scheduler.
//
// Handshake semantics (both requesters, index r = 0/1):
//   req_valid[r]  level from the requester, held with a stable req_desc slice
//                 until the scheduler pulses req_ready[r] for one cycle; the
//                 transfer happens on the clock edge where both are high.
//   rsp_valid[r]  level from the scheduler, held with rsp_status until the
//                 owner raises rsp_ack[r]; release happens on the edge where
//                 both are high.
//   grant         one-hot owner of the engine while a job is in flight.
//
// Signals:
//   req_valid[1:0]    request per requester
//   req_desc[127:0]   descriptor per requester, requester r at [64r+63:64r]
//                     {op[63:32], n[31:24], m[23:16], wb[15:8], p[7:0]}
//   req_ready[1:0]    one-cycle accept pulse
//   rsp_valid[1:0]    response level to the owner
//   rsp_status[1:0]   00 ok, 01 bad opcode, 10 bad dimensions, 11 timeout
//   rsp_ack[1:0]      owner release
//   grant[1:0]        one-hot owner
interface matmul_scheduler_if;
  logic [1:0]   req_valid;
  logic [127:0] req_desc;
  logic [1:0]   req_ready;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_status;
  logic [1:0]   rsp_ack;
  logic [1:0]   grant;

  // Requester side.
  modport master (
    output req_valid, req_desc, rsp_ack,
    input  req_ready, rsp_valid, rsp_status, grant
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_desc, rsp_ack,
    output req_ready, rsp_valid, rsp_status, grant
  );
endinterface

// File: rtl/matmul_scheduler.sv
// matmul_scheduler: round-robin arbiter and job sequencer for the shared
// matrix multiplication engine.
//
// A job is accepted from one of two requesters, validated, the engine's
// accumulating result array is cleared with a one-cycle engine reset, the
// engine is enabled until it reports done (or the job times out), and the
// result is held for the owner until it acknowledges.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high
//   bus        requester handshake bundle (slave modport)
//   busy       FSM is not IDLE
//   mm_reset   engine reset (high during reset and in CLEAR)
//   mm_enable  engine enable (RUN, dropped as soon as an armed done is seen)
//   mm_n/m/p   zero-extended latched dimensions for the engine
//   mm_done    engine done
//   dbg_state  current FSM state encoding
module matmul_scheduler #(
  parameter int          SEQ_BITS       = 14,
  parameter logic [31:0] OP_MATMUL      = 32'd1,
  parameter int          TIMEOUT_CYCLES = 8192
) (
  input  logic                clk,
  input  logic                reset,
  matmul_scheduler_if.slave   bus,
  output logic                busy,
  output logic                mm_reset,
  output logic                mm_enable,
  output logic [31:0]         mm_n,
  output logic [31:0]         mm_m,
  output logic [31:0]         mm_p,
  input  logic                mm_done,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam int          DIM_MAX = SEQ_BITS + 1;
  localparam logic [31:0] TMAX    = 32'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BAD_OP  = 2'b01;
  localparam logic [1:0] ST_BAD_DIM = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  state_t      state, state_d;
  logic        last_grant;
  logic        owner;
  logic [31:0] op_q;
  logic [7:0]  n_q, m_q, wb_q, p_q;
  logic [1:0]  status_q, status_d;
  logic [31:0] timer_q;
  logic        armed_q;

  logic        accept;
  logic        winner;
  logic        dims_bad;
  logic        done_hit;
  logic        timeout_hit;
  logic [1:0]  owner_oh;
  logic [1:0]  winner_oh;

  function automatic logic dim_bad(input logic [7:0] d);
    return (d == 8'd0) || (int'(d) > DIM_MAX);
  endfunction

  // Round robin: with both requesting, the one not served last wins;
  // otherwise the only valid requester wins.
  assign winner    = (&bus.req_valid) ? ~last_grant : bus.req_valid[1];
  assign winner_oh = winner ? 2'b10 : 2'b01;
  assign owner_oh  = owner ? 2'b10 : 2'b01;

  assign dims_bad    = dim_bad(n_q) || dim_bad(m_q) || dim_bad(p_q) || (wb_q != m_q);
  // Done is only believed once the engine has been seen low in this run;
  // the done=1 left behind by CLEAR is stale.
  assign done_hit    = armed_q && mm_done;
  assign timeout_hit = (timer_q == TMAX);

  always_comb begin
    state_d  = state;
    status_d = status_q;
    accept   = 1'b0;
    case (state)
      S_IDLE: begin
        if (|bus.req_valid) begin
          accept  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (op_q != OP_MATMUL) begin
          status_d = ST_BAD_OP;
          state_d  = S_RESP;
        end else if (dims_bad) begin
          status_d = ST_BAD_DIM;
          state_d  = S_RESP;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        if (done_hit) begin
          status_d = ST_OK;
          state_d  = S_RESP;
        end else if (timeout_hit) begin
          status_d = ST_TIMEOUT;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ack[owner]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from state; enable drops combinationally on an armed done
  // so the engine does not run a cycle past completion.
  always_comb begin
    bus.req_ready  = (accept && !reset) ? winner_oh : 2'b00;
    bus.grant      = (state != S_IDLE) ? owner_oh : 2'b00;
    bus.rsp_valid  = (state == S_RESP) ? owner_oh : 2'b00;
    bus.rsp_status = status_q;
    busy           = (state != S_IDLE);
    mm_reset       = reset || (state == S_CLEAR);
    mm_enable      = (state == S_RUN) && !done_hit;
    mm_n           = {24'd0, n_q};
    mm_m           = {24'd0, m_q};
    mm_p           = {24'd0, p_q};
    dbg_state      = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_q       <= '0;
      n_q        <= '0;
      m_q        <= '0;
      wb_q       <= '0;
      p_q        <= '0;
      status_q   <= ST_OK;
      timer_q    <= '0;
      armed_q    <= 1'b0;
    end else begin
      state    <= state_d;
      status_q <= status_d;
      if (accept) begin
        owner      <= winner;
        last_grant <= winner;
        {op_q, n_q, m_q, wb_q, p_q} <= winner ? bus.req_desc[127:64] : bus.req_desc[63:0];
      end
      if (state == S_CLEAR) begin
        timer_q <= '0;
        armed_q <= 1'b0;
      end
      if (state == S_RUN) begin
        timer_q <= timer_q + 32'd1;
        if (!mm_done) armed_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matmul_scheduler.sv
module tb_matmul_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matmul_scheduler_if bus();

  logic        busy, mm_reset, mm_enable;
  logic        mm_done = 1'b1;
  logic [31:0] mm_n, mm_m, mm_p;
  logic [2:0]  dbg_state;

  matmul_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .mm_reset  (mm_reset),
    .mm_enable (mm_enable),
    .mm_n      (mm_n),
    .mm_m      (mm_m),
    .mm_p      (mm_p),
    .mm_done   (mm_done),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_rst    = 0;
  int n_en     = 0;

  logic [3:0] exp_q[$];  // {owner one-hot, status}

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      if (mm_reset)  n_rst++;
      if (mm_enable) n_en++;
    end
  end

  // Mock engine: done goes low on the first enabled cycle after a clear and
  // comes back run_len cycles later. In stale mode done stays at 1.
  logic stale_mode = 1'b0;
  int   run_len    = 20;
  logic running    = 1'b0;
  int   ecnt       = 0;
  always @(posedge clk) begin
    if (mm_reset) begin
      mm_done <= 1'b1;
      running <= 1'b0;
      ecnt    <= 0;
    end else if (mm_enable && !stale_mode) begin
      if (!running) begin
        running <= 1'b1;
        mm_done <= 1'b0;
        ecnt    <= 0;
      end else if (ecnt == run_len - 1) begin
        mm_done <= 1'b1;
      end else begin
        ecnt <= ecnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [1:0] prev_rv = 2'b00;
  logic [3:0] mon_e;
  always @(negedge clk) begin
    if (bus.rsp_valid != 2'b00 && prev_rv == 2'b00) begin
      check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("rsp_owner_status", 32'({bus.rsp_valid, bus.rsp_status}), 32'(mon_e));
      end
    end
    prev_rv = bus.rsp_valid;
  end

  // ---------------- driver tasks ----------------
  function automatic logic [63:0] mk(input logic [31:0] op, input logic [7:0] n,
                                     input logic [7:0] m, input logic [7:0] wb,
                                     input logic [7:0] p);
    return {op, n, m, wb, p};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ack   = 2'b00;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check("rst_mm_reset", 32'(mm_reset), 32'd1);
    check("rst_outs", 32'({busy, bus.grant, bus.rsp_valid, bus.rsp_status, bus.req_ready, mm_enable}), 32'd0);
    check("rst_dims", mm_n | mm_m | mm_p, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int k;
    k = 0;
    while (bus.rsp_valid == 2'b00 && k < 9000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_rsp_seen"}, 32'(bus.rsp_valid != 2'b00), 32'd1);
  endtask

  task automatic do_job(input string tag, input int r, input logic [63:0] d,
                        input logic [1:0] st, input int lat, input int e_rst, input int e_en);
    int k, c0, br, be;
    logic [1:0] oh;
    oh = (r == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    br = n_rst;
    be = n_en;
    if (r == 1) bus.req_desc[127:64] = d;
    else        bus.req_desc[63:0]   = d;
    bus.req_valid = bus.req_valid | oh;
    exp_q.push_back({oh, st});
    #1;
    k = 0;
    while ((bus.req_ready & oh) == 2'b00 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({tag, "_ready"}, 32'(bus.req_ready), 32'(oh));
    c0 = cyc;
    @(negedge clk);
    bus.req_valid = bus.req_valid & ~oh;
    wait_rsp(tag);
    check({tag, "_latency"}, cyc - c0, lat);
    check({tag, "_en_in_resp"}, 32'(mm_enable), 32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_hold"}, 32'({bus.rsp_valid, bus.grant, bus.rsp_status}), 32'({oh, oh, st}));
    bus.rsp_ack = oh;
    @(negedge clk);
    bus.rsp_ack = 2'b00;
    check({tag, "_release"}, 32'({busy, bus.grant, bus.rsp_valid}), 32'd0);
    check({tag, "_dims"}, {8'd0, mm_n[7:0], mm_m[7:0], mm_p[7:0]}, {8'd0, d[31:24], d[23:16], d[7:0]});
    check({tag, "_n_mm_reset"}, n_rst - br, e_rst);
    check({tag, "_n_mm_enable"}, n_en - be, e_en);
  endtask

  // ---------------- directed sequence ----------------
  logic [63:0] ok_desc;
  initial begin
    int k, bad;
    logic tb_last;
    logic [1:0] exp_oh;

    reset         = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_desc  = '0;
    bus.rsp_ack   = 2'b00;
    ok_desc       = mk(32'd1, 8'd2, 8'd2, 8'd2, 8'd2);
    do_reset();

    // Single ok job: accept T, clear T+2, run T+3.., done high T+24, rsp T+25.
    do_job("single", 0, ok_desc, 2'b00, 25, 1, 21);

    // Both requesters valid every cycle: alternating accepts from a fresh reset.
    do_reset();
    tb_last = 1'b1;
    bus.req_desc = {ok_desc, ok_desc};
    @(negedge clk);
    bus.req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      #1;
      k = 0;
      while (bus.req_ready == 2'b00 && k < 20) begin
        @(negedge clk);
        #1;
        k++;
      end
      exp_oh  = tb_last ? 2'b01 : 2'b10;
      tb_last = ~tb_last;
      check("rr_order", 32'(bus.req_ready), 32'(exp_oh));
      exp_q.push_back({exp_oh, 2'b00});
      bad = 0;
      k   = 0;
      @(negedge clk);
      while (bus.rsp_valid == 2'b00 && k < 200) begin
        if (bus.grant != exp_oh) bad++;
        @(negedge clk);
        k++;
      end
      if (bus.grant != exp_oh) bad++;
      check("rr_grant_onehot", bad, 0);
      bus.rsp_ack = exp_oh;
      if (j == 3) bus.req_valid = 2'b00;
      @(negedge clk);
      bus.rsp_ack = 2'b00;
    end
    @(negedge clk);
    check("rr_idle_after", 32'(busy), 32'd0);

    // Validation failures: response at T+2, engine never touched.
    do_job("bad_op",  0, mk(32'd2, 8'd2,  8'd2, 8'd2, 8'd2), 2'b01, 2, 0, 0);
    do_job("op_prio", 1, mk(32'd2, 8'd16, 8'd2, 8'd2, 8'd2), 2'b01, 2, 0, 0);
    do_job("n16",     1, mk(32'd1, 8'd16, 8'd2, 8'd2, 8'd2), 2'b10, 2, 0, 0);
    do_job("m0",      0, mk(32'd1, 8'd2,  8'd0, 8'd0, 8'd2), 2'b10, 2, 0, 0);
    do_job("wb3",     1, mk(32'd1, 8'd2,  8'd2, 8'd3, 8'd2), 2'b10, 2, 0, 0);
    do_job("p0",      0, mk(32'd1, 8'd2,  8'd2, 8'd2, 8'd0), 2'b10, 2, 0, 0);
    do_job("max15",   1, mk(32'd1, 8'd15, 8'd15, 8'd15, 8'd15), 2'b00, 25, 1, 21);

    // Stale done never drops: timeout TIMEOUT_CYCLES after RUN entry (T+3).
    stale_mode = 1'b1;
    do_job("timeout", 0, ok_desc, 2'b11, 3 + 8192, 1, 8192);
    stale_mode = 1'b0;

    // Owner withholds ack while the other requester waits.
    @(negedge clk);
    bus.req_desc  = {ok_desc, ok_desc};
    bus.req_valid = 2'b01;
    exp_q.push_back({2'b01, 2'b00});
    #1;
    check("hold_ready0", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 2'b10;
    wait_rsp("hold_job0");
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      #1;
      if (bus.grant != 2'b01 || bus.rsp_valid != 2'b01 || bus.req_ready != 2'b00) bad++;
    end
    check("hold_50", bad, 0);
    bus.rsp_ack = 2'b01;
    @(negedge clk);
    bus.rsp_ack = 2'b00;
    #1;
    check("hold_next_accept", 32'({bus.req_ready, bus.rsp_valid}), 32'({2'b10, 2'b00}));
    exp_q.push_back({2'b10, 2'b00});
    @(negedge clk);
    bus.req_valid = 2'b00;
    wait_rsp("hold_job1");
    bus.rsp_ack = 2'b10;
    @(negedge clk);
    bus.rsp_ack = 2'b00;

    // Reset during RUN aborts the job with no response.
    @(negedge clk);
    bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = 2'b00;
    k = 0;
    while (!mm_enable && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check("abort_in_run", 32'(dbg_state), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check("abort_outs", 32'({busy, bus.grant, bus.rsp_valid, bus.rsp_status, bus.req_ready, mm_enable}), 32'd0);
    check("abort_mm_reset", 32'(mm_reset), 32'd1);
    check("abort_dims", mm_n | mm_m | mm_p, 32'd0);
    reset = 1'b0;
    do_job("after_abort", 0, ok_desc, 2'b00, 25, 1, 21);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
